// File: rtl/gray_counter_n.sv
// Parametrised Gray-code counter with up/down, synchronous load, wrap or
// saturate at the terminal count, and a ripple-carry output for cascading.
module gray_counter_n #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cten,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] bin,
    output logic             tc,
    output logic             rc
);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("gray_counter_n: WIDTH must be in 2..16");
    end

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_next_bin;
    logic             w_tc;
    logic             w_advance;
    logic             w_update;

    assign w_tc       = up ? (r_bin == {WIDTH{1'b1}}) : (r_bin == '0);
    assign w_step     = up ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));
    // At the terminal count the step is the modulo wrap, so only saturation blocks it.
    assign w_advance  = cten & (~w_tc | WRAP);
    assign w_update   = load | w_advance;
    assign w_next_bin = load ? load_val : w_step;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else if (w_update) begin
            r_bin  <= w_next_bin;
            r_gray <= w_next_bin ^ (w_next_bin >> 1);
        end
    end

    assign out = r_gray;
    assign bin = r_bin;
    assign tc  = w_tc;
    assign rc  = w_tc & cten;

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed bench for gray_counter_n: reset, full up/down sweeps, saturate,
// load priority and a two-stage cascade.
module tb_gray_counter_n;

    logic       clk = 1'b0;
    logic       clr = 1'b0;

    logic       d_cten = 1'b0, d_up = 1'b1, d_load = 1'b0;
    logic [3:0] d_load_val = 4'd0;
    logic [3:0] d_out, d_bin;
    logic       d_tc, d_rc;

    logic       s_cten = 1'b0, s_up = 1'b1;
    logic [3:0] s_load_val = 4'd0;
    logic       s_load = 1'b0;
    logic [3:0] s_out, s_bin;
    logic       s_tc, s_rc;

    logic       c_cten = 1'b0;
    logic       c_load = 1'b0;
    logic [3:0] c_load_val = 4'd0;
    logic [3:0] lo_out, lo_bin, hi_out, hi_bin;
    logic       lo_tc, lo_rc, hi_tc, hi_rc;

    int checks = 0;
    int errors = 0;

    logic [3:0] up_seq [0:16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                  4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    always #5 clk = ~clk;

    gray_counter_n #(.WIDTH(4), .WRAP(1'b1)) u_dut (
        .clk(clk), .clr(clr), .cten(d_cten), .up(d_up), .load(d_load),
        .load_val(d_load_val), .out(d_out), .bin(d_bin), .tc(d_tc), .rc(d_rc));

    gray_counter_n #(.WIDTH(4), .WRAP(1'b0)) u_sat (
        .clk(clk), .clr(clr), .cten(s_cten), .up(s_up), .load(s_load),
        .load_val(s_load_val), .out(s_out), .bin(s_bin), .tc(s_tc), .rc(s_rc));

    gray_counter_n #(.WIDTH(4), .WRAP(1'b1)) u_lo (
        .clk(clk), .clr(clr), .cten(c_cten), .up(1'b1), .load(c_load),
        .load_val(c_load_val), .out(lo_out), .bin(lo_bin), .tc(lo_tc), .rc(lo_rc));

    gray_counter_n #(.WIDTH(4), .WRAP(1'b1)) u_hi (
        .clk(clk), .clr(clr), .cten(lo_rc), .up(1'b1), .load(c_load),
        .load_val(c_load_val), .out(hi_out), .bin(hi_bin), .tc(hi_tc), .rc(hi_rc));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("[%s] observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] prev;
        logic [3:0] exp_b;

        // Reset state while clr is low
        #1;
        chk("rst_out", 16'(d_out), 16'h0);
        chk("rst_bin", 16'(d_bin), 16'h0);
        chk("rst_tc_up", 16'(d_tc), 16'h0);
        chk("rst_rc", 16'(d_rc), 16'h0);
        #1;
        clr    = 1'b1;
        d_cten = 1'b1;
        d_up   = 1'b1;

        // Full up sequence with wrap
        prev = d_out;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("up_out_%0d", i), 16'(d_out), 16'(up_seq[i]));
            chk($sformatf("up_tc_%0d", i), 16'(d_tc), 16'(up_seq[i] == 4'b1000));
            chk($sformatf("up_ham_%0d", i), 16'($countones(d_out ^ prev)), 16'd1);
            prev = d_out;
        end

        // Count to 0110 then assert clr between edges
        repeat (4) step();
        chk("pre_rst_out", 16'(d_out), 16'b0110);
        d_cten = 1'b0;
        #3;
        clr = 1'b0;
        #1;
        chk("async_out", 16'(d_out), 16'h0);
        chk("async_bin", 16'(d_bin), 16'h0);
        chk("async_tc_up", 16'(d_tc), 16'h0);
        d_up = 1'b0;
        #1;
        chk("async_tc_dn", 16'(d_tc), 16'h1);
        chk("async_rc_nocten", 16'(d_rc), 16'h0);
        d_cten = 1'b1;
        #1;
        chk("async_rc_cten", 16'(d_rc), 16'h1);
        clr = 1'b1;

        // Down from 0: wraps to 15, tc only at bin 0
        step();
        chk("dn_first_out", 16'(d_out), 16'b1000);
        chk("dn_first_bin", 16'(d_bin), 16'd15);
        step();
        chk("dn_second_out", 16'(d_out), 16'b1001);
        chk("dn_second_bin", 16'(d_bin), 16'd14);
        exp_b = 4'd14;
        for (int i = 0; i < 14; i++) begin
            step();
            exp_b = exp_b - 4'd1;
            chk($sformatf("dn_bin_%0d", exp_b), 16'(d_bin), 16'(exp_b));
            chk($sformatf("dn_out_%0d", exp_b), 16'(d_out), 16'(exp_b ^ (exp_b >> 1)));
            chk($sformatf("dn_tc_%0d", exp_b), 16'(d_tc), 16'(exp_b == 4'd0));
        end

        // Load wins over count
        d_load     = 1'b1;
        d_load_val = 4'd10;
        d_cten     = 1'b1;
        d_up       = 1'b1;
        step();
        chk("load_bin", 16'(d_bin), 16'd10);
        chk("load_out", 16'(d_out), 16'b1111);
        d_load = 1'b0;
        d_cten = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("load_hold_%0d", i), 16'(d_out), 16'b1111);
        end

        // Saturating instance
        s_up   = 1'b1;
        s_cten = 1'b1;
        repeat (15) step();
        chk("sat_bin", 16'(s_bin), 16'd15);
        chk("sat_out", 16'(s_out), 16'b1000);
        chk("sat_tc", 16'(s_tc), 16'h1);
        chk("sat_rc", 16'(s_rc), 16'h1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("sat_hold_%0d", i), 16'(s_out), 16'b1000);
        end
        chk("sat_hold_rc", 16'(s_rc), 16'h1);
        s_up = 1'b0;
        #1;
        chk("sat_dn_tc", 16'(s_tc), 16'h0);
        step();
        chk("sat_dn_out", 16'(s_out), 16'b1001);
        chk("sat_dn_bin", 16'(s_bin), 16'd14);
        s_cten = 1'b0;

        // Two-stage cascade counting 0..255 and wrapping
        c_cten = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            step();
            chk($sformatf("casc_%0d", i), {8'h0, hi_bin, lo_bin}, 16'(i % 256));
            if (i == 255) begin
                chk("casc_lo_rc", 16'(lo_rc), 16'h1);
                chk("casc_hi_tc", 16'(hi_tc), 16'h1);
                chk("casc_hi_rc", 16'(hi_rc), 16'h1);
                chk("casc_hi_out", 16'(hi_out), 16'b1000);
                chk("casc_lo_out", 16'(lo_out), 16'b1000);
            end
        end
        c_cten = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
